ball_motion_ctrl: RTL
=====================

Name: ball_motion_ctrl

Overview:
- Frame-synchronous motion controller for the on-screen ball.
- Synchronises VGA_VS into the 50 MHz domain and produces a one-cycle frame tick.
- Samples the USB keycode on each tick, runs a direction FSM with wall-bounce, and updates BallX/BallY/BallS for color_mapper.
- Replaces clocking ball logic directly off VGA_VS; everything runs on MAX10_CLK1_50.

Parameters:
- STEP, 1, pixels moved per frame (1..15)
- SIZE, 4, ball half-size driven on BallS
- CENTER_X, 320, reset X position
- CENTER_Y, 240, reset Y position
- X_MIN, 0, left wall; X_MAX, 639, right wall
- Y_MIN, 0, top wall; Y_MAX, 479, bottom wall

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- vsync  in  1  VGA_VS from vga_controller, asynchronous to Clk
- keycode  in  8  last USB keycode from the SoC PIO
- BallX  out  10  ball centre X
- BallY  out  10  ball centre Y
- BallS  out  10  ball half-size, constant SIZE
- frame_tick  out  1  one-cycle pulse per frame
- dir  out  3  FSM state: 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
- frame_cnt  out  16  frames since reset, wraps 0xFFFF->0

Behaviour:
- Reset (async, active-high), all regs cleared immediately:
  - BallX=CENTER_X, BallY=CENTER_Y, BallS=SIZE
  - dir=STOP, frame_tick=0, frame_cnt=0
  - sync flops=1 (no false tick on release)
- Sync and tick:
  - vsync passes through 2 flops, then a third flop holds the previous value.
  - Falling edge (prev=1, cur=0) registers frame_tick=1 for exactly one Clk.
  - Latency: 3-4 Clk after vsync falls.
- On the frame_tick cycle (all results visible the following cycle):
  1. Key decode:
     - 0x1A W -> UP; 0x16 S -> DOWN; 0x04 A -> LEFT; 0x07 D -> RIGHT
     - Any other value, including 0x00 -> keep current dir
  2. Wall check on the candidate dir, using 11-bit unsigned arithmetic (no wrap):
     - UP and BallY-SIZE < Y_MIN+STEP -> DOWN
     - DOWN and BallY+SIZE+STEP > Y_MAX -> UP
     - LEFT and BallX-SIZE < X_MIN+STEP -> RIGHT
     - RIGHT and BallX+SIZE+STEP > X_MAX -> LEFT
     - A bounce overrides the key in the same frame.
  3. Position update by ±STEP along the final dir; STOP leaves X/Y unchanged.
     - Only one axis moves per frame.
  4. frame_cnt increments by 1.
- Outside tick cycles, all outputs hold.
- The ball edge never passes a wall; BallX-SIZE>=X_MIN and BallX+SIZE<=X_MAX always hold.
- keycode is sampled only on tick cycles; changes between ticks are ignored.
- A Reset assertion mid-frame aborts any pending update; the first tick after release uses reset values.
- vsync held constant -> no ticks, outputs frozen.

Optional Feature:
- BALL_KEY_RELEASE_STOP_EN
  - Defined: keycode==0x00 on a tick forces dir=STOP, and the ball halts on key release. Unknown nonzero codes still keep the current dir.
  - Undefined: 0x00 keeps the current dir, so the ball coasts until a new key or a wall.

Test Plan:
- Reset pulse mid-motion -> next cycle BallX=320, BallY=240, BallS=4, dir=0, frame_cnt=0, frame_tick=0.
- keycode=0x07, 10 vsync falling edges -> BallX=330, BallY=240, dir=4, frame_cnt=10; exactly 10 one-cycle frame_tick pulses.
- Force BallX=634 with keycode=0x07 held; run ticks:
  - Tick 1 -> BallX 635
  - Tick 2 -> dir=3 (LEFT), BallX=634
  - Tick 3 -> RIGHT again, BallX=635
- keycode=0x1A from Y=240 for 236 ticks -> BallY=4; next tick -> dir=2 (DOWN), BallY=5.
- keycode toggles 0x04->0x55->0x00 between ticks, then one tick:
  - Without the macro -> LEFT retained, BallX decrements by 1.
  - With BALL_KEY_RELEASE_STOP_EN -> dir=0, BallX unchanged.
- vsync glitch-free but held high for 5 frames -> no frame_tick, outputs constant; frame_cnt wrap checked by preloading 0xFFFF -> 0x0000 after one tick.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: frame-synchronous motion controller for the on-screen ball.
//
// VGA_VS (vsync) is brought into the Clk domain through a two-flop synchroniser.
// A third flop keeps the previous synchronised value, and each falling edge of
// vsync produces a one-cycle frame_tick. On a tick the controller samples
// keycode, runs the direction FSM with wall bounce, moves the ball by STEP
// pixels along one axis and counts the frame. Outputs hold between ticks.
//
// Ports:
//   Clk        in   system clock (50 MHz)
//   Reset      in   asynchronous, active-high reset
//   vsync      in   VGA_VS, asynchronous to Clk
//   keycode    in   [7:0] last USB keycode (W=0x1A, S=0x16, A=0x04, D=0x07)
//   BallX      out  [9:0] ball centre X
//   BallY      out  [9:0] ball centre Y
//   BallS      out  [9:0] ball half-size (constant SIZE)
//   frame_tick out  one-cycle pulse per frame
//   dir        out  [2:0] 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
//   frame_cnt  out  [15:0] frames since reset, wrapping
//
// Optional feature macro: BALL_KEY_RELEASE_STOP_EN
//   Defined:   keycode 0x00 on a tick stops the ball.
//   Undefined: keycode 0x00 keeps the current direction (ball coasts).

module ball_motion_ctrl #(
  parameter int unsigned STEP     = 1,
  parameter int unsigned SIZE     = 4,
  parameter int unsigned CENTER_X = 320,
  parameter int unsigned CENTER_Y = 240,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned Y_MAX    = 479
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [7:0]  keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  BallS,
  output logic        frame_tick,
  output logic [2:0]  dir,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    StStop  = 3'd0,
    StUp    = 3'd1,
    StDown  = 3'd2,
    StLeft  = 3'd3,
    StRight = 3'd4
  } dir_e;

  // Wall limits in 11 bits so the sums below cannot wrap. The low-wall test
  // Ball-SIZE < MIN+STEP is rewritten as Ball < MIN+STEP+SIZE to avoid a
  // subtraction.
  localparam logic [10:0] XLoLim = 11'(X_MIN + STEP + SIZE);
  localparam logic [10:0] YLoLim = 11'(Y_MIN + STEP + SIZE);
  localparam logic [10:0] XHiLim = 11'(X_MAX);
  localparam logic [10:0] YHiLim = 11'(Y_MAX);
  localparam logic [10:0] SzStep = 11'(SIZE + STEP);
  localparam logic [9:0]  Step10 = 10'(STEP);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic        tick_q, tick_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  dir_e        dir_q, dir_d;
  logic [15:0] cnt_q, cnt_d;

  dir_e        dir_cand;
  dir_e        dir_fin;
  logic [10:0] x_ext;
  logic [10:0] y_ext;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  always_comb begin
    // Synchroniser and falling-edge detector
    sync1_d = vsync;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = prev_q & ~sync2_q;

    // Key decode; unknown codes keep the current direction
    dir_cand = dir_q;
    case (keycode)
      8'h1A:   dir_cand = StUp;
      8'h16:   dir_cand = StDown;
      8'h04:   dir_cand = StLeft;
      8'h07:   dir_cand = StRight;
`ifdef BALL_KEY_RELEASE_STOP_EN
      8'h00:   dir_cand = StStop;
`endif
      default: dir_cand = dir_q;
    endcase

    // Bounce overrides the key when the next step would cross a wall
    dir_fin = dir_cand;
    case (dir_cand)
      StUp:    if (y_ext < YLoLim)          dir_fin = StDown;
      StDown:  if (y_ext + SzStep > YHiLim) dir_fin = StUp;
      StLeft:  if (x_ext < XLoLim)          dir_fin = StRight;
      StRight: if (x_ext + SzStep > XHiLim) dir_fin = StLeft;
      default: dir_fin = dir_cand;
    endcase

    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (tick_q) begin
      dir_d = dir_fin;
      cnt_d = cnt_q + 16'd1;
      case (dir_fin)
        StUp:    y_d = y_q - Step10;
        StDown:  y_d = y_q + Step10;
        StLeft:  x_d = x_q - Step10;
        StRight: x_d = x_q + Step10;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // Sync chain idles high so releasing reset with vsync high is not an edge
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      tick_q  <= 1'b0;
      x_q     <= 10'(CENTER_X);
      y_q     <= 10'(CENTER_Y);
      dir_q   <= StStop;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BallX      = x_q;
  assign BallY      = y_q;
  assign BallS      = 10'(SIZE);
  assign frame_tick = tick_q;
  assign dir        = dir_q;
  assign frame_cnt  = cnt_q;

endmodule
